uma_mem_requester: RTL and testbench

Initiator side of the UMA internal-memory handshake (rreq/wreq/addr/wdata/rdata/busy/ack). Accepts read/write commands from a client through a small command FIFO, issues them one at a time to the memory, waits for ack, and returns read data or a timeout error to the client. It sits between the CPU/bus front end and InternalMemory.

---
 rtl/uma_pkg.sv | 26 ++
 rtl/uma_mem_requester_if.sv | 43 ++++
 rtl/uma_cmd_fifo.sv | 55 +++++
 rtl/uma_mem_requester.sv | 145 ++++++++++++++
 tb/tb_uma_mem_requester.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uma_pkg
// Brief    : Shared types and defaults for the UMA memory requester
// Revision : 1.0 - initial release
// ============================================================================
package uma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  localparam int c_DEFAULT_DEPTH   = 4;
  localparam int c_DEFAULT_TIMEOUT = 64;
  localparam int c_CMD_W           = $bits(cmd_t);

endpackage
`default_nettype wire

// File: rtl/uma_mem_requester_if.sv
`default_nettype none
// ============================================================================
// Module   : uma_mem_requester_if
// Brief    : Client command/response and memory handshake bundle
// Revision : 1.0 - initial release
// ============================================================================
interface uma_mem_requester_if;
  // client side
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_we;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // memory side
  logic        mem_rreq;
  logic        mem_wreq;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_ack;

  // requester view
  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_we, resp_rdata, resp_err,
    output mem_rreq, mem_wreq, mem_addr, mem_wdata,
    input  mem_rdata, mem_busy, mem_ack
  );

  // client plus memory view
  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_we, resp_rdata, resp_err,
    input  mem_rreq, mem_wreq, mem_addr, mem_wdata,
    output mem_rdata, mem_busy, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/uma_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uma_cmd_fifo
// Brief    : Synchronous FIFO with extra-bit pointers for full/empty
// Revision : 1.0 - initial release
// ============================================================================
module uma_cmd_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_din,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_dout,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_ONE = {{c_AW{1'b0}}, 1'b1};

  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  // Same index with differing wrap bits means every slot is occupied.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr[c_AW-1:0]];

  // Pointer update; push and pop in one cycle both advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ONE;
    end
  end

  // Storage write; contents need no reset because empty gates reads.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_din;
  end

endmodule
`default_nettype wire

// File: rtl/uma_mem_requester.sv
`default_nettype none
// ============================================================================
// Module   : uma_mem_requester
// Brief    : Queues client commands and issues them one at a time to memory
// Revision : 1.0 - initial release
// ============================================================================
module uma_mem_requester
  import uma_pkg::*;
#(
  parameter int DEPTH   = c_DEFAULT_DEPTH,
  parameter int TIMEOUT = c_DEFAULT_TIMEOUT
) (
  input wire logic             clk,
  input wire logic             reset,
  uma_mem_requester_if.master  bus
);

  localparam int c_CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  cmd_t                w_req_cmd;
  cmd_t                w_head;
  cmd_t                r_issue;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_start;
  logic                w_ack_done;
  logic                w_timeout;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_rreq;
  logic                r_wreq;
  logic                r_resp_valid;
  logic                r_resp_we;
  logic                r_resp_err;
  logic [31:0]         r_resp_rdata;

  assign w_req_cmd = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};

  uma_cmd_fifo #(
    .WIDTH (c_CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.req_valid),
    .i_din   (w_req_cmd),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and single-cycle control strobes; an ack beats a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_ack_done  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!bus.mem_busy) begin
          w_start     = 1'b1;
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (bus.mem_ack) begin
          w_ack_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Issue register, request levels and wait counter; the counter stops at TIMEOUT at most.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_issue <= '0;
      r_rreq  <= 1'b0;
      r_wreq  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_pop) r_issue <= w_head;
      if (w_start) begin
        r_rreq <= !r_issue.we;
        r_wreq <= r_issue.we;
        r_cnt  <= '0;
      end else begin
        if (w_ack_done || w_timeout) begin
          r_rreq <= 1'b0;
          r_wreq <= 1'b0;
        end
        if (r_state == ST_WAIT_ACK) r_cnt <= r_cnt + c_CNT_ONE;
      end
    end
  end

  // Completion pulse; data and error fields are zero outside the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_resp_we    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= w_ack_done || w_timeout;
      r_resp_we    <= (w_ack_done || w_timeout) && r_issue.we;
      r_resp_err   <= w_timeout;
      r_resp_rdata <= (w_ack_done && !r_issue.we) ? bus.mem_rdata : 32'd0;
    end
  end

  assign bus.req_ready  = !w_full;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_we    = r_resp_we;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_rreq   = r_rreq;
  assign bus.mem_wreq   = r_wreq;
  assign bus.mem_addr   = r_issue.addr;
  assign bus.mem_wdata  = r_issue.wdata;

endmodule
`default_nettype wire

// File: tb/tb_uma_mem_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_uma_mem_requester
// Brief    : Scoreboard bench for uma_mem_requester with a simple memory model
// Revision : 1.0 - initial release
// ============================================================================
module tb_uma_mem_requester;

  logic clk;
  logic reset;
  uma_mem_requester_if bus ();

  uma_mem_requester #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic we; logic [31:0] rdata; logic err;} rsp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} mreq_t;

  rsp_t  exp_q [$];
  mreq_t mexp_q [$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_resp = 0;
  logic  noack_en;
  logic [31:0] mm      [256];
  logic [31:0] ref_mem [256];

  // memory model: acks in the first request cycle unless the stuck address is selected
  assign bus.mem_ack   = (bus.mem_rreq || bus.mem_wreq) &&
                         !(noack_en && bus.mem_addr == 32'h0000_4000);
  assign bus.mem_rdata = mm[bus.mem_addr[19:12]];

  // memory model write port
  always @(posedge clk) begin
    if (bus.mem_wreq && bus.mem_ack) mm[bus.mem_addr[19:12]] <= bus.mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (reset && bus.resp_valid) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("resp_we", bus.resp_we, e.we);
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_err", bus.resp_err, e.err);
        end
      end
    end
  end

  // memory request monitor
  initial begin
    logic  prev;
    mreq_t cur;
    prev = 1'b0;
    cur  = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (bus.mem_rreq || bus.mem_wreq) begin
        check("req_exclusive", bus.mem_rreq & bus.mem_wreq, 0);
        if (!prev) begin
          if (mexp_q.size() == 0) check("unexpected_req", 1, 0);
          else cur = mexp_q.pop_front();
        end
        check("mem_we", bus.mem_wreq, cur.we);
        check("mem_addr", bus.mem_addr, cur.addr);
        if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
      end
      prev = bus.mem_rreq || bus.mem_wreq;
    end
  end

  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit wait_rdy, input bit exp_acc);
    int budget;
    @(negedge clk);
    if (wait_rdy) begin
      budget = 0;
      while (!bus.req_ready && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      if (!bus.req_ready) check("ready_wait", bus.req_ready, 1);
    end else begin
      check("req_ready", bus.req_ready, exp_acc);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    if (exp_acc) begin
      mexp_q.push_back('{we, addr, wdata});
      if (we) begin
        exp_q.push_back('{1'b1, 32'd0, 1'b0});
        ref_mem[addr[19:12]] = wdata;
      end else if (noack_en && addr == 32'h0000_4000) begin
        exp_q.push_back('{1'b0, 32'd0, 1'b1});
      end else begin
        exp_q.push_back('{1'b0, ref_mem[addr[19:12]], 1'b0});
      end
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  // watchdog
  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    reset = 1'b0;
    noack_en = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.mem_busy = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mm[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_rreq", bus.mem_rreq, 0);
    check("rst_wreq", bus.mem_wreq, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_rdata", bus.resp_rdata, 0);
    check("rst_err", bus.resp_err, 0);
    reset = 1'b1;

    // minimum latency
    send(1'b1, 32'h000F_F000, 32'h0000_A5A5, 1'b0, 1'b1);
    @(negedge clk); check("lat_n0", bus.mem_wreq, 0);
    @(negedge clk); check("lat_n1", bus.mem_wreq, 0);
    @(negedge clk); check("lat_n2", bus.mem_wreq, 1);
    @(negedge clk); check("lat_resp", bus.resp_valid, 1);
    check("lat_drop", bus.mem_wreq, 0);
    wait_drain(20);

    // sequential writes then read-back
    for (int i = 0; i < 50; i++) send(1'b1, 32'(i) * 32'h1000, 32'h1234 + 32'(i), 1'b1, 1'b1);
    wait_drain(400);
    for (int i = 0; i < 50; i++) send(1'b0, 32'(i) * 32'h1000, 32'h0, 1'b1, 1'b1);
    wait_drain(400);

    // busy stall
    @(negedge clk); bus.mem_busy = 1'b1;
    send(1'b1, 32'h0000_7000, 32'h0000_BEEF, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_noreq", bus.mem_rreq | bus.mem_wreq, 0);
    end
    bus.mem_busy = 1'b0;
    @(negedge clk); check("stall_release", bus.mem_wreq, 1);
    wait_drain(20);

    // FIFO full: one command parked in WAIT_BUSY, then DEPTH+1 pushes
    @(negedge clk); bus.mem_busy = 1'b1;
    send(1'b0, 32'h0000_2000, 32'h0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 5; i++)
      send(1'b1, 32'h0001_0000 + 32'(i) * 32'h1000, 32'hF000 + 32'(i), 1'b0, i < 4);
    @(negedge clk); check("full_ready", bus.req_ready, 0);
    base = n_resp;
    bus.mem_busy = 1'b0;
    wait_drain(100);
    repeat (5) @(negedge clk);
    check("full_nresp", n_resp - base, 5);

    // timeout followed by a normal command
    noack_en = 1'b1;
    send(1'b0, 32'h0000_4000, 32'h0, 1'b1, 1'b1);
    send(1'b1, 32'h0000_5000, 32'h0000_5555, 1'b1, 1'b1);
    n = 0;
    while (!bus.mem_rreq && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (bus.mem_rreq && n < 200) begin n++; @(negedge clk); end
    check("timeout_len", n, 64);
    wait_drain(50);
    noack_en = 1'b0;

    // reset while waiting for ack
    noack_en = 1'b1;
    send(1'b0, 32'h0000_4000, 32'h0, 1'b1, 1'b1);
    n = 0;
    while (!bus.mem_rreq && n < 20) begin @(negedge clk); n++; end
    #2 reset = 1'b0;
    #1 check("rst_mid_rreq", bus.mem_rreq, 0);
    check("rst_mid_ready", bus.req_ready, 1);
    check("rst_mid_pending", exp_q.size(), 1);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_noresp", bus.resp_valid, 0);
    end
    reset = 1'b1;
    noack_en = 1'b0;
    send(1'b1, 32'h0000_6000, 32'h0000_6666, 1'b1, 1'b1);
    wait_drain(20);
    check("post_rst_mem", mm[8'h06], 32'h0000_6666);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
